// File: rtl/ir_fetch_sequencer.sv
`timescale 1ns/1ps
// ir_fetch_sequencer
// Sequences a two-byte instruction fetch from an 8-bit memory port into the
// 16-bit instruction register, stepping the program counter after each byte.
// The control unit issues one Fetch request (or a Clear), and this block
// drives the IR and PC control strobes. Memory reads are bounded by a wait
// counter; if a byte does not arrive in time, the block reports Timeout.
//
// Ports
//   Clock, Reset        rising-edge clock, asynchronous active-low reset
//   Fetch, Clear        requests, sampled only while idle (Clear wins)
//   MemRd               read strobe, high while waiting for a byte
//   MemValid, MemData   byte return from memory
//   IR_E/IR_FunSel/IR_LH/IR_Input   IR controls and registered byte
//   PC_E/PC_FunSel      PC controls (11 = increment)
//   Busy, Done, Timeout status: not idle, completion pulse, sticky error
//   state_dbg           current FSM state, for observation only
//
// Memory handshake: MemRd is the request and MemValid the response. A byte
// transfers on a rising edge where MemRd and MemValid are both high. MemValid
// is ignored whenever MemRd is low. MemRd is never withdrawn before a byte
// arrives, except when the wait budget runs out.
module ir_fetch_sequencer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Fetch,
  input  logic             Clear,
  output logic             MemRd,
  input  logic             MemValid,
  input  logic [7:0]       MemData,
  output logic             IR_E,
  output logic [1:0]       IR_FunSel,
  output logic             IR_LH,
  output logic [7:0]       IR_Input,
  output logic             PC_E,
  output logic [1:0]       PC_FunSel,
  output logic             Busy,
  output logic             Done,
  output logic             Timeout,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_REQ_L  = 3'd2,
    S_LOAD_L = 3'd3,
    S_REQ_H  = 3'd4,
    S_LOAD_H = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  // The counter holds the number of wait cycles already spent on the current
  // byte, so the last allowed read cycle is the one where it equals this value.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [7:0]       ir_input_nxt;
  logic             timeout_nxt;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      IR_Input <= 8'h00;
      Timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      IR_Input <= ir_input_nxt;
      Timeout  <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    ir_input_nxt = IR_Input;
    timeout_nxt  = Timeout;
    MemRd        = 1'b0;
    IR_E         = 1'b0;
    IR_FunSel    = 2'b00;
    IR_LH        = 1'b0;
    PC_E         = 1'b0;
    PC_FunSel    = 2'b00;
    Done         = 1'b0;
    Busy         = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (Clear) begin
          state_nxt = S_CLR;
        end else if (Fetch) begin
          state_nxt    = S_REQ_L;
          timeout_nxt  = 1'b0;
          wait_cnt_nxt = '0;
        end
      end
      S_CLR: begin
        // IR_FunSel stays 00: a plain IR clear.
        IR_E      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_REQ_L, S_REQ_H: begin
        MemRd = 1'b1;
        if (MemValid) begin
          ir_input_nxt = MemData;
          state_nxt    = (state == S_REQ_L) ? S_LOAD_L : S_LOAD_H;
        end else if (wait_cnt == LAST_WAIT) begin
          state_nxt = S_ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      S_LOAD_L: begin
        IR_E         = 1'b1;
        IR_FunSel    = 2'b01;
        PC_E         = 1'b1;
        PC_FunSel    = 2'b11;
        state_nxt    = S_REQ_H;
        wait_cnt_nxt = '0;
      end
      S_LOAD_H: begin
        IR_E      = 1'b1;
        IR_FunSel = 2'b01;
        IR_LH     = 1'b1;
        PC_E      = 1'b1;
        PC_FunSel = 2'b11;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        Done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        // A low byte already loaded (failure on the high byte) is left in
        // place, and the PC keeps its single increment.
        timeout_nxt = 1'b1;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
`timescale 1ns/1ps
// Bench for ir_fetch_sequencer. A reactive memory responder returns bytes
// after a chosen number of wait cycles. A timeline model turns each planned
// fetch into the expected IR/PC/Done events, and these are compared against
// the events the bench observes.
module tb_ir_fetch_sequencer;

  localparam int TO    = 15;
  localparam int NEVER = 99;

  logic       Clock, Reset, Fetch, Clear, MemValid;
  logic [7:0] MemData;
  logic       MemRd, IR_E, IR_LH, PC_E, Busy, Done, Timeout;
  logic [1:0] IR_FunSel, PC_FunSel;
  logic [7:0] IR_Input;
  logic [2:0] state_dbg;

  ir_fetch_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .Fetch(Fetch), .Clear(Clear),
    .MemRd(MemRd), .MemValid(MemValid), .MemData(MemData),
    .IR_E(IR_E), .IR_FunSel(IR_FunSel), .IR_LH(IR_LH), .IR_Input(IR_Input),
    .PC_E(PC_E), .PC_FunSel(PC_FunSel), .Busy(Busy), .Done(Done),
    .Timeout(Timeout), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          resp_w[$];
  logic [7:0]  resp_d[$];
  int          cyc, rd_cnt;
  bit          served;
  int          memrd_cycles, busy_cycles, exp_memrd, exp_busy;
  logic        exp_to = 1'b0;
  logic [15:0] ir_obs = 16'h0000;
  logic [15:0] exp_ir = 16'h0000;

  // Event record: kind[31:28] cycle[27:16] data[15:0].
  // kind 1 IR strobe {FunSel,LH,00000,byte}, 2 PC strobe, 3 Done,
  // 4 control lines active without their enable.
  function automatic logic [31:0] ev(input int kind, input int c, input logic [15:0] d);
    return {kind[3:0], c[11:0], d};
  endfunction

  function automatic logic [31:0] obs_at(input int i);
    return (i < obs_q.size()) ? obs_q[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] exp_at(input int i);
    return (i < exp_q.size()) ? exp_q[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic int ev_mismatch();
    int n;
    n = (obs_q.size() > exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (obs_at(i) !== exp_at(i)) return i;
    return -1;
  endfunction

  // ---------------- reference model ----------------
  // Timeline of one fetch whose REQ_L cycle is s. wl/wh are the wait cycles
  // before each byte is returned (>= TO means the byte never comes). Also
  // queues the responder's bytes. Returns the first idle cycle afterwards.
  task automatic plan_fetch(input int s, input int wl, input int wh,
                            input logic [7:0] bl, input logic [7:0] bh,
                            output int idle_c);
    int t;
    resp_w.push_back(wl);
    resp_d.push_back(bl);
    if (wl >= TO) begin
      exp_memrd += TO;
      exp_to     = 1'b1;
      idle_c     = s + TO + 1;
    end else begin
      resp_w.push_back(wh);
      resp_d.push_back(bh);
      exp_memrd += wl + 1;
      t = s + wl + 1;
      exp_q.push_back(ev(1, t, {8'h40, bl}));
      exp_q.push_back(ev(2, t, 16'h0003));
      exp_ir[7:0] = bl;
      if (wh >= TO) begin
        exp_memrd += TO;
        exp_to     = 1'b1;
        idle_c     = t + TO + 2;
      end else begin
        exp_memrd += wh + 1;
        t = t + wh + 2;
        exp_q.push_back(ev(1, t, {8'h60, bh}));
        exp_q.push_back(ev(2, t, 16'h0003));
        exp_q.push_back(ev(3, t + 1, 16'h0000));
        exp_ir[15:8] = bh;
        exp_to       = 1'b0;
        idle_c       = t + 2;
      end
    end
    exp_busy += idle_c - s;
  endtask

  // ---------------- driver / monitor ----------------
  task automatic begin_scn();
    exp_q.delete();
    obs_q.delete();
    resp_w.delete();
    resp_d.delete();
    cyc          = 0;
    rd_cnt       = 0;
    served       = 1'b0;
    memrd_cycles = 0;
    busy_cycles  = 0;
    exp_memrd    = 0;
    exp_busy     = 0;
  endtask

  // One cycle: sample this cycle's outputs on the falling edge, then set up
  // the memory response for the next rising edge.
  task automatic step();
    @(negedge Clock);
    cyc++;
    if (IR_E) begin
      obs_q.push_back(ev(1, cyc, {IR_FunSel, IR_LH, 5'd0, (IR_FunSel == 2'b01) ? IR_Input : 8'h00}));
      if (IR_FunSel == 2'b01) begin
        if (IR_LH) ir_obs[15:8] = IR_Input;
        else       ir_obs[7:0]  = IR_Input;
      end else if (IR_FunSel == 2'b00) begin
        ir_obs = 16'h0000;
      end
    end
    if (PC_E) obs_q.push_back(ev(2, cyc, {14'd0, PC_FunSel}));
    if (Done) obs_q.push_back(ev(3, cyc, 16'h0000));
    if ((!IR_E && (IR_FunSel != 2'b00 || IR_LH)) || (!PC_E && PC_FunSel != 2'b00))
      obs_q.push_back(ev(4, cyc, {11'd0, IR_FunSel, IR_LH, PC_FunSel}));
    if (MemRd) memrd_cycles++;
    if (Busy)  busy_cycles++;

    if (MemRd) begin
      if (!served && resp_w.size() > 0 && rd_cnt == resp_w[0]) begin
        MemValid = 1'b1;
        MemData  = resp_d[0];
        void'(resp_w.pop_front());
        void'(resp_d.pop_front());
        served = 1'b1;
      end else begin
        MemValid = 1'b0;
        MemData  = 8'($urandom);
      end
      rd_cnt++;
    end else begin
      // A read that ended without a byte was abandoned by a timeout.
      if (rd_cnt > 0 && !served && resp_w.size() > 0) begin
        void'(resp_w.pop_front());
        void'(resp_d.pop_front());
      end
      rd_cnt   = 0;
      served   = 1'b0;
      MemValid = 1'($urandom_range(0, 1));
      MemData  = 8'($urandom);
    end
  endtask

  task automatic run_to(input int last);
    while (cyc < last) step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b0; Fetch = 1'b0; Clear = 1'b0; MemValid = 1'b0; MemData = 8'h00;
    #12;
    n_checks++; if ({MemRd, IR_E, IR_FunSel, IR_LH, IR_Input, PC_E, PC_FunSel, Busy, Done, Timeout, state_dbg} !== 23'd0) begin n_fail++; $display("FAIL rst_init outputs got %h exp 0", {MemRd, IR_E, IR_FunSel, IR_LH, IR_Input, PC_E, PC_FunSel, Busy, Done, Timeout, state_dbg}); end
    @(negedge Clock);
    Reset = 1'b1;
    begin_scn();
    resp_w.push_back(0);     resp_d.push_back(8'h5A);
    resp_w.push_back(NEVER); resp_d.push_back(8'h00);
    exp_q.push_back(ev(1, 2, 16'h405A));
    exp_q.push_back(ev(2, 2, 16'h0003));
    exp_ir[7:0] = 8'h5A;
    Fetch = 1'b1;
    step();
    Fetch = 1'b0;
    run_to(4);
    n_checks++; if (MemRd !== 1'b1) begin n_fail++; $display("FAIL rst_pre_memrd got %b exp 1", MemRd); end
    n_checks++; if (ev_mismatch() >= 0) begin n_fail++; $display("FAIL rst_pre_events idx %0d got %h exp %h", ev_mismatch(), obs_at(ev_mismatch()), exp_at(ev_mismatch())); end
    #2 Reset = 1'b0;
    #1;
    n_checks++; if ({MemRd, IR_E, IR_FunSel, IR_LH, IR_Input, PC_E, PC_FunSel, Busy, Done, Timeout, state_dbg} !== 23'd0) begin n_fail++; $display("FAIL rst_async outputs got %h exp 0", {MemRd, IR_E, IR_FunSel, IR_LH, IR_Input, PC_E, PC_FunSel, Busy, Done, Timeout, state_dbg}); end
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    begin_scn();
    run_to(6);
    n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL rst_after_events got %0d exp 0", obs_q.size()); end
    n_checks++; if (busy_cycles !== 0) begin n_fail++; $display("FAIL rst_after_busy got %0d exp 0", busy_cycles); end
    n_checks++; if (memrd_cycles !== 0) begin n_fail++; $display("FAIL rst_after_memrd got %0d exp 0", memrd_cycles); end
    n_checks++; if (Timeout !== 1'b0) begin n_fail++; $display("FAIL rst_after_timeout got %b exp 0", Timeout); end
    n_checks++; if (ir_obs !== exp_ir) begin n_fail++; $display("FAIL rst_after_ir got %h exp %h", ir_obs, exp_ir); end
  endtask

  task automatic test_zero_wait();
    int idle_c;
    begin_scn();
    plan_fetch(1, 0, 0, 8'h3C, 8'hA5, idle_c);
    Fetch = 1'b1; step(); Fetch = 1'b0;
    run_to(idle_c + 2);
    n_checks++; if (ev_mismatch() >= 0) begin n_fail++; $display("FAIL zw_events idx %0d got %h exp %h", ev_mismatch(), obs_at(ev_mismatch()), exp_at(ev_mismatch())); end
    n_checks++; if (memrd_cycles !== exp_memrd) begin n_fail++; $display("FAIL zw_memrd got %0d exp %0d", memrd_cycles, exp_memrd); end
    n_checks++; if (busy_cycles !== exp_busy) begin n_fail++; $display("FAIL zw_busy got %0d exp %0d", busy_cycles, exp_busy); end
    n_checks++; if (ir_obs !== 16'hA53C) begin n_fail++; $display("FAIL zw_ir got %h exp a53c", ir_obs); end
    n_checks++; if (Timeout !== 1'b0) begin n_fail++; $display("FAIL zw_timeout got %b exp 0", Timeout); end
  endtask

  task automatic test_wait3();
    int idle_c;
    begin_scn();
    plan_fetch(1, 3, 3, 8'($urandom), 8'($urandom), idle_c);
    Fetch = 1'b1; step(); Fetch = 1'b0;
    run_to(idle_c + 2);
    n_checks++; if (ev_mismatch() >= 0) begin n_fail++; $display("FAIL w3_events idx %0d got %h exp %h", ev_mismatch(), obs_at(ev_mismatch()), exp_at(ev_mismatch())); end
    n_checks++; if (memrd_cycles !== 8) begin n_fail++; $display("FAIL w3_memrd got %0d exp 8", memrd_cycles); end
    n_checks++; if (Timeout !== 1'b0) begin n_fail++; $display("FAIL w3_timeout got %b exp 0", Timeout); end
    n_checks++; if (ir_obs !== exp_ir) begin n_fail++; $display("FAIL w3_ir got %h exp %h", ir_obs, exp_ir); end
  endtask

  // Single fetch with the given waits; used for timeout, last-wait and random runs.
  task automatic test_fetch(input string name, input int wl, input int wh);
    int idle_c;
    begin_scn();
    plan_fetch(1, wl, wh, 8'($urandom), 8'($urandom), idle_c);
    Fetch = 1'b1; step(); Fetch = 1'b0;
    run_to(idle_c + 2);
    n_checks++; if (ev_mismatch() >= 0) begin n_fail++; $display("FAIL %s_events idx %0d got %h exp %h", name, ev_mismatch(), obs_at(ev_mismatch()), exp_at(ev_mismatch())); end
    n_checks++; if (memrd_cycles !== exp_memrd) begin n_fail++; $display("FAIL %s_memrd got %0d exp %0d", name, memrd_cycles, exp_memrd); end
    n_checks++; if (busy_cycles !== exp_busy) begin n_fail++; $display("FAIL %s_busy got %0d exp %0d", name, busy_cycles, exp_busy); end
    n_checks++; if (Timeout !== exp_to) begin n_fail++; $display("FAIL %s_timeout got %b exp %b", name, Timeout, exp_to); end
    n_checks++; if (ir_obs !== exp_ir) begin n_fail++; $display("FAIL %s_ir got %h exp %h", name, ir_obs, exp_ir); end
    n_checks++; if (MemRd !== 1'b0) begin n_fail++; $display("FAIL %s_memrd_idle got %b exp 0", name, MemRd); end
  endtask

  task automatic test_clear_fetch();
    int idle_c;
    begin_scn();
    exp_q.push_back(ev(1, 1, 16'h0000));
    exp_ir   = 16'h0000;
    exp_busy = 1;
    plan_fetch(3, 0, 0, 8'($urandom), 8'($urandom), idle_c);
    Fetch = 1'b1; Clear = 1'b1;
    step();                      // cycle 1: clear
    Clear = 1'b0;
    run_to(3);                   // cycle 3: fetch has started
    Fetch = 1'b0;
    step();                      // cycle 4: requests while busy
    Fetch = 1'b1; Clear = 1'b1;
    step();
    Fetch = 1'b0; Clear = 1'b0;
    run_to(idle_c + 2);
    n_checks++; if (ev_mismatch() >= 0) begin n_fail++; $display("FAIL clr_events idx %0d got %h exp %h", ev_mismatch(), obs_at(ev_mismatch()), exp_at(ev_mismatch())); end
    n_checks++; if (busy_cycles !== exp_busy) begin n_fail++; $display("FAIL clr_busy got %0d exp %0d", busy_cycles, exp_busy); end
    n_checks++; if (memrd_cycles !== exp_memrd) begin n_fail++; $display("FAIL clr_memrd got %0d exp %0d", memrd_cycles, exp_memrd); end
    n_checks++; if (ir_obs !== exp_ir) begin n_fail++; $display("FAIL clr_ir got %h exp %h", ir_obs, exp_ir); end
  endtask

  task automatic test_back_to_back();
    int s, idle_c;
    begin_scn();
    s = 1;
    for (int k = 0; k < 3; k++) begin
      plan_fetch(s, 0, 0, 8'($urandom), 8'($urandom), idle_c);
      if (k < 2) s = idle_c + 1;
    end
    Fetch = 1'b1;
    run_to(s);                   // third fetch has begun
    Fetch = 1'b0;
    run_to(idle_c + 3);
    n_checks++; if (ev_mismatch() >= 0) begin n_fail++; $display("FAIL b2b_events idx %0d got %h exp %h", ev_mismatch(), obs_at(ev_mismatch()), exp_at(ev_mismatch())); end
    n_checks++; if (busy_cycles !== 15) begin n_fail++; $display("FAIL b2b_busy got %0d exp 15", busy_cycles); end
    n_checks++; if (memrd_cycles !== 6) begin n_fail++; $display("FAIL b2b_memrd got %0d exp 6", memrd_cycles); end
    n_checks++; if (ir_obs !== exp_ir) begin n_fail++; $display("FAIL b2b_ir got %h exp %h", ir_obs, exp_ir); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    int wl, wh;
    test_reset();
    test_zero_wait();
    test_wait3();
    test_fetch("to_low", NEVER, 0);
    test_fetch("recover", 0, 0);
    test_fetch("to_high", $urandom_range(0, 14), NEVER);
    test_fetch("last_wait", 14, 14);
    test_clear_fetch();
    test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      wl = $urandom_range(0, 15);
      wh = $urandom_range(0, 15);
      test_fetch("rand", (wl == 15) ? NEVER : wl, (wh == 15) ? NEVER : wh);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
